// File: rtl/ram8_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram8_fifo_ctrl : 9-entry valid/ready FIFO built from one ram8 plus an output
//                  holding register.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram8_fifo_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WIDTH-1:0]  ram_in,
  output logic              ram_load,
  input  logic [WIDTH-1:0]  ram_out
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              take;
  logic              read_sel;
  logic              bypass;
  logic              push;

  assign take     = !out_valid | out_ready;
  assign read_sel = take & (ram_cnt != '0);
  assign bypass   = take & (ram_cnt == '0);
  assign in_ready = bypass | (!read_sel & (ram_cnt < DEPTH));
  assign push     = in_valid & in_ready;

  // The single RAM port serves a read in preference to a write.
  assign ram_address = read_sel ? rd_ptr : wr_ptr;
  assign ram_load    = push & !bypass;
  assign ram_in      = in_data;
  assign count       = ram_cnt + {{ADDR_W{1'b0}}, out_valid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (read_sel) begin
        out_data  <= ram_out;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
        ram_cnt   <= ram_cnt - 1'b1;
      end else if (bypass) begin
        if (push) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      // A RAM write never coincides with a read: in_ready is low when read_sel.
      if (push && !bypass) begin
        wr_ptr  <= wr_ptr + 1'b1;
        ram_cnt <= ram_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram8_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram8_fifo_ctrl : randomized bench for ram8_fifo_ctrl against a queue model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram8_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic [2:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  always #5 clk = ~clk;

  ram8_fifo_ctrl #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .ram_address(ram_address), .ram_in(ram_in),
    .ram_load(ram_load), .ram_out(ram_out)
  );

  // ram8 stand-in: combinational read, write on the rising edge when loaded.
  logic [15:0] mem [8];
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  // Model: the FIFO is a queue; RAM traffic is counted in writes and reads.
  logic [15:0] q [$];
  int unsigned n_wr, n_rd;
  int          tests, fails;
  logic        s_ready, s_load;
  logic [2:0]  s_addr;
  logic        popped;
  logic [15:0] last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    n_wr = 0;
    n_rd = 0;
  endtask

  // One clock: drive at the falling edge, check before the rising edge, then advance the model.
  task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy);
    int   sz;
    logic exp_ready, pop, psh, rd, ld;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    sz        = q.size();
    exp_ready = (sz <= 1) || (!ordy && sz < 9);
    pop       = (sz > 0) && ordy;
    psh       = iv && exp_ready;
    rd        = ordy && (sz >= 2);
    ld        = psh && ((sz - int'(pop)) >= 1);
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    if (sz > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    chk("count", 32'(count), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("ram_load", 32'(ram_load), 32'(ld));
    chk("ram_in", 32'(ram_in), 32'(d));
    chk("ram_address", 32'(ram_address), rd ? 32'(n_rd % 8) : 32'(n_wr % 8));
    s_ready = in_ready;
    s_load  = ram_load;
    s_addr  = ram_address;
    popped  = pop;
    if (pop) last_pop = q[0];
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (psh) q.push_back(d);
    if (rd)  n_rd++;
    if (ld)  n_wr++;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && q.size() > 0; k++) cycle(1'b0, 16'h0, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int guard;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    model_clear();

    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      out_ready = 1'($urandom);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_ram_load", 32'(ram_load), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b1;

    // Bypass into an empty FIFO
    cycle(1'b1, 16'h1234, 1'b0);
    chk("t2_load", 32'(s_load), 32'd0);
    #1;
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'h1234);
    chk("t2_count", 32'(count), 32'd1);
    drain();

    // Fill to 9, then drain in order
    for (int i = 1; i <= 9; i++) cycle(1'b1, 16'(i), 1'b0);
    #1;
    chk("t3_count", 32'(count), 32'd9);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 16'h0, 1'b1);
      chk("t3_order", 32'(last_pop), 32'(i));
    end
    #1;
    chk("t3_empty", 32'(count), 32'd0);

    // Randomized traffic with phases of varying back-pressure
    for (int ph = 0; ph < 8; ph++) begin
      int pv, pr;
      pv = 20 + 10 * int'($urandom_range(0, 7));
      pr = 20 + 10 * int'($urandom_range(0, 7));
      for (int i = 0; i < 60; i++)
        cycle(1'($urandom_range(0, 99) < pv), 16'($urandom), 1'($urandom_range(0, 99) < pr));
    end
    chk("t4_wrapped", 32'(n_wr >= 16), 32'd1);
    drain();

    // Reset mid-operation at count 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t6_pre_count", 32'(count), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    #1;
    reset_n = 1'b1;
    model_clear();
    cycle(1'b1, 16'hBEEF, 1'b0);
    chk("t6_bypass_load", 32'(s_load), 32'd0);
    #1;
    chk("t6_bypass_valid", 32'(out_valid), 32'd1);
    chk("t6_bypass_data", 32'(out_data), 32'hBEEF);

    // Contention: head held, three words in RAM at addresses 0..2
    cycle(1'b1, 16'h0B0B, 1'b0);
    cycle(1'b1, 16'h0C0C, 1'b0);
    cycle(1'b1, 16'h0D0D, 1'b0);
    #1;
    chk("t5_count", 32'(count), 32'd4);
    cycle(1'b1, 16'h0E0E, 1'b1);
    chk("t5_ready", 32'(s_ready), 32'd0);
    chk("t5_load", 32'(s_load), 32'd0);
    chk("t5_addr", 32'(s_addr), 32'd0);
    guard = 1;
    while (!s_ready && guard < 10) begin
      cycle(1'b1, 16'h0E0E, 1'b1);
      guard++;
    end
    chk("t5_accept_cycle", 32'(guard), 32'd4);
    drain();
    chk("t5_last", 32'(last_pop), 32'h0E0E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
